// File: rtl/mux_sel_arb_if.sv
// Handshake bundle for mux_sel_arb: two valid/ready sources in, one registered word plus mux select out.
interface mux_sel_arb_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] a;
   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] b;
   logic             b_valid;
   logic             b_ready;
   logic             s;
   logic [WIDTH-1:0] y;
   logic             y_valid;
   logic             y_ready;

   // Arbiter side
   modport slave (
      input  a, a_valid, b, b_valid, y_ready,
      output a_ready, b_ready, s, y, y_valid
   );

   // Producer/consumer side
   modport master (
      output a, a_valid, b, b_valid, y_ready,
      input  a_ready, b_ready, s, y, y_valid
   );
endinterface

// File: rtl/mux_sel_arb.sv
// Two-source arbiter into a one-word output register; 1-cycle latency, alternating priority on ties.
// Readies drop while y holds an unconsumed word; MUX_SEL_ARB_CNT_EN adds saturating per-source accept counters.
module mux_sel_arb #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   mux_sel_arb_if.slave bus
`ifdef MUX_SEL_ARB_CNT_EN
   ,
   output logic [7:0]   cnt_a,
   output logic [7:0]   cnt_b
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic             pri;
   logic             tie;
   logic             grant_a;
   logic             grant_b;
   logic             accept_en;
   logic             accept;
   logic [WIDTH-1:0] y_q;
   logic             s_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      tie       = bus.a_valid & bus.b_valid;
      grant_a   = bus.a_valid & (~bus.b_valid | ~pri);
      grant_b   = bus.b_valid & (~bus.a_valid | pri);
      accept_en = (state == EMPTY) | (bus.y_ready & (state == FULL));
      accept    = accept_en & (grant_a | grant_b);
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nx = FULL;
            end
         end
         FULL: begin
            // A consumed word is replaced in the same cycle when a source is waiting.
            if (bus.y_ready) begin
               state_nx = accept ? FULL : EMPTY;
            end
         end
         default: state_nx = EMPTY;
      endcase
   end

   // Reset forces state to EMPTY, which alone would raise accept_en; gate it off explicitly.
   assign bus.a_ready = accept_en & grant_a & ~rst;
   assign bus.b_ready = accept_en & grant_b & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q <= '0;
         s_q <= 1'b0;
         pri <= 1'b0;
      end else if (accept) begin
         y_q <= grant_b ? bus.b : bus.a;
         s_q <= grant_b;
         if (tie) begin
            pri <= ~grant_b;
         end
      end
   end

   assign bus.y       = y_q;
   assign bus.s       = s_q;
   assign bus.y_valid = (state == FULL);

`ifdef MUX_SEL_ARB_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_a <= 8'd0;
         cnt_b <= 8'd0;
      end else begin
         if (accept & grant_a & (cnt_a != 8'hFF)) begin
            cnt_a <= cnt_a + 8'd1;
         end
         if (accept & grant_b & (cnt_b != 8'hFF)) begin
            cnt_b <= cnt_b + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mux_sel_arb.sv
// Directed and random stimulus for mux_sel_arb against a transaction-level reference model.
module tb_mux_sel_arb;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mux_sel_arb_if #(.WIDTH(W)) bus ();

`ifdef MUX_SEL_ARB_CNT_EN
   logic [7:0] cnt_a;
   logic [7:0] cnt_b;
   mux_sel_arb #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus), .cnt_a(cnt_a), .cnt_b(cnt_b));
`else
   mux_sel_arb #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the output word register plus the tie-break pointer.
   logic         m_full;
   logic [W-1:0] m_y;
   logic         m_s;
   logic         m_pri;
   int           m_cnt_a;
   int           m_cnt_b;

   task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_full  = 1'b0;
      m_y     = '0;
      m_s     = 1'b0;
      m_pri   = 1'b0;
      m_cnt_a = 0;
      m_cnt_b = 0;
   endtask

   // Called right after a falling edge; returns right after the next falling edge.
   task automatic step(input logic av, input logic [W-1:0] ad, input logic bv, input logic [W-1:0] bd,
                       input logic yr, input string tag);
      logic take;
      logic pick_b;
      bus.a_valid = av;
      bus.a       = ad;
      bus.b_valid = bv;
      bus.b       = bd;
      bus.y_ready = yr;
      take   = (!m_full || yr) && (av || bv);
      pick_b = bv && (!av || m_pri);
      #1;
      check(tag, "a_ready", 32'(bus.a_ready), 32'(take && !pick_b));
      check(tag, "b_ready", 32'(bus.b_ready), 32'(take && pick_b));
      @(posedge clk);
      if (take) begin
         m_y    = pick_b ? bd : ad;
         m_s    = pick_b;
         m_full = 1'b1;
         if (av && bv) m_pri = !pick_b;
         if (pick_b) m_cnt_b = (m_cnt_b < 255) ? m_cnt_b + 1 : 255;
         else        m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
      end else if (m_full && yr) begin
         m_full = 1'b0;
      end
      #1;
      check(tag, "y", 32'(bus.y), 32'(m_y));
      check(tag, "y_valid", 32'(bus.y_valid), 32'(m_full));
      check(tag, "s", 32'(bus.s), 32'(m_s));
`ifdef MUX_SEL_ARB_CNT_EN
      check(tag, "cnt_a", 32'(cnt_a), 32'(m_cnt_a));
      check(tag, "cnt_b", 32'(cnt_b), 32'(m_cnt_b));
`endif
      @(negedge clk);
   endtask

   initial begin
      int exp_s [4];
      exp_s = '{0, 1, 0, 1};

      // Reset with a source already valid: readies must stay low.
      rst         = 1'b1;
      bus.a_valid = 1'b1;
      bus.a       = 8'h5A;
      bus.b_valid = 1'b1;
      bus.b       = 8'hA5;
      bus.y_ready = 1'b1;
      model_reset();
      #2;
      check("reset", "y", 32'(bus.y), 32'h0);
      check("reset", "y_valid", 32'(bus.y_valid), 32'h0);
      check("reset", "s", 32'(bus.s), 32'h0);
      check("reset", "a_ready", 32'(bus.a_ready), 32'h0);
      check("reset", "b_ready", 32'(bus.b_ready), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Single word from a.
      step(1'b1, 8'h11, 1'b0, 8'h00, 1'b1, "single_a");
      check("single_a", "y_exp", 32'(bus.y), 32'h11);

      // Ties alternate a, b, a, b.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b1, "tie_alt");
         check("tie_alt", "s_seq", 32'(bus.s), 32'(exp_s[i]));
      end

      // Stall while FULL with both valid, then release.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'h44, 1'b1, 8'h55, 1'b0, "stall");
      end
      step(1'b1, 8'h44, 1'b1, 8'h55, 1'b1, "stall_release");
      check("stall_release", "s_after", 32'(bus.s), 32'h0);
      step(1'b1, 8'h66, 1'b1, 8'h77, 1'b1, "tie_back_to_b");
      check("tie_back_to_b", "y_exp", 32'(bus.y), 32'h77);

      // Drain, then b alone twice; pointer must stay on a.
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "drain");
      step(1'b0, 8'h00, 1'b1, 8'h22, 1'b1, "b_only1");
      step(1'b0, 8'h00, 1'b1, 8'h33, 1'b1, "b_only2");
      check("b_only2", "y_exp", 32'(bus.y), 32'h33);
      step(1'b1, 8'h88, 1'b1, 8'h99, 1'b1, "tie_after_b");
      check("tie_after_b", "s_exp", 32'(bus.s), 32'h0);

      // Reset while FULL takes effect without a clock edge.
      step(1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, "pre_rst");
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst", "y", 32'(bus.y), 32'h0);
      check("mid_rst", "y_valid", 32'(bus.y_valid), 32'h0);
      check("mid_rst", "s", 32'(bus.s), 32'h0);
      check("mid_rst", "b_ready", 32'(bus.b_ready), 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 2) != 0), 8'($urandom),
              1'($urandom_range(0, 2) != 0), 8'($urandom),
              1'($urandom_range(0, 3) != 0), "random");
      end

`ifdef MUX_SEL_ARB_CNT_EN
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 8'(i), 1'b0, 8'h00, 1'b1, "cnt_sat");
      end
      check("cnt_sat", "cnt_a_final", 32'(cnt_a), 32'd255);
      check("cnt_sat", "cnt_b_final", 32'(cnt_b), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
